// File: rtl/mem_slave_ctrl_pkg.sv
// Shared types and constants for the memory slave controller.
// Provides default bus widths, data/address types, FSM states and op codes.
package mem_pkg;

  localparam int MEM_WIDTH      = 8;
  localparam int MEM_ADDR_WIDTH = 4;

  typedef logic [MEM_WIDTH-1:0]      data_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_slave_ctrl_if.sv
// Memory request/response bus: wr_rd/addr/wdata/valid from the master,
// registered rdata and a one-cycle ready pulse from the slave.
interface mem_slave_ctrl_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic                  valid;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;

  modport master (
    output wr_rd, addr, wdata, valid,
    input  rdata, ready
  );

  modport slave (
    input  wr_rd, addr, wdata, valid,
    output rdata, ready
  );

endinterface

// File: rtl/mem_slave_ctrl_array.sv
// DEPTH x WIDTH storage, async clear, one write port and one registered
// read port with enable. Out-of-range writes drop, reads return zero.
module mem_array #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             w_ok;
  logic             r_ok;
  logic [IW-1:0]    widx;
  logic [IW-1:0]    ridx;

  assign w_ok = {1'b0, waddr} < LIMIT;
  assign r_ok = {1'b0, raddr} < LIMIT;
  assign widx = waddr[IW-1:0];
  assign ridx = raddr[IW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && w_ok)
        mem[widx] <= wdata;
      if (re)
        rdata <= r_ok ? mem[ridx] : '0;
    end
  end

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory slave: accepts one read/write at a time, answers with a single
// ready pulse; reads return after RD_LAT cycles. Ports: clk, res, bus.
module mem_slave_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int RD_LAT     = 2
) (
  input logic clk,
  input logic res,
  mem_slave_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_WAIT = RD_WAIT;
  localparam logic [1:0] ST_RESP = RESP;

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);
  localparam bit         LAT1     = (RD_LAT == 1);

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ready_q;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      rdata_w;

  assign accept = (state == ST_IDLE) && bus.valid;
  assign wr_en  = accept && (bus.wr_rd == WR);

  // With RD_LAT = 1 the array is read at the acceptance edge itself,
  // so the live address is used; otherwise the latched one.
  assign rd_en = (accept && (bus.wr_rd == RD) && LAT1)
              || ((state == ST_WAIT) && (cnt == 4'd1));
  assign rd_addr = (state == ST_IDLE) ? bus.addr : addr_q;

  mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (res),
    .we    (wr_en),
    .waddr (bus.addr),
    .wdata (bus.wdata),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rdata_w)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (bus.valid) begin
            addr_q <= bus.addr;
            if (bus.wr_rd == WR || LAT1) begin
              state   <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state   <= ST_RESP;
            ready_q <= 1'b1;
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_w;

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Directed bench for mem_slave_ctrl: reset, write/read, back-to-back,
// out-of-range, reset mid-read and read-latency sweep.
module tb_mem_slave_ctrl;

  logic clk;
  logic res;
  int   checks;
  int   errors;

  mem_slave_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(4)) m ();
  mem_slave_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(4)) b1 ();
  mem_slave_ctrl_if #(.WIDTH(8), .ADDR_WIDTH(4)) b4 ();

  mem_slave_ctrl #(
    .WIDTH(8), .ADDR_WIDTH(4), .DEPTH(8), .RD_LAT(2)
  ) u_dut (
    .clk (clk),
    .res (res),
    .bus (m)
  );

  mem_slave_ctrl #(
    .WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RD_LAT(1)
  ) u_l1 (
    .clk (clk),
    .res (res),
    .bus (b1)
  );

  mem_slave_ctrl #(
    .WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .RD_LAT(4)
  ) u_l4 (
    .clk (clk),
    .res (res),
    .bus (b4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the main DUT. valid stays high through the RESP
  // edge so a second acceptance would show up as an extra ready.
  task automatic xact(input  logic       w,
                      input  logic [3:0] a,
                      input  logic [7:0] d,
                      output int         lat,
                      output logic [7:0] rd);
    lat = 0;
    rd  = '0;
    @(negedge clk);
    m.valid = 1'b1;
    m.wr_rd = w;
    m.addr  = a;
    m.wdata = d;
    @(posedge clk);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      #1;
      if (m.ready === 1'b1) begin
        lat = k;
        rd  = m.rdata;
      end else begin
        @(posedge clk);
      end
    end
    @(posedge clk);
    #1 chk("pulse_end", m.ready, 0);
    @(negedge clk);
    m.valid = 1'b0;
    @(posedge clk);
    #1 chk("no_reaccept", m.ready, 0);
  endtask

  int         lat;
  logic [7:0] rd;
  int         lat1, lat4, np1, np4;
  logic [7:0] rd1, rd4;

  initial begin
    checks = 0;
    errors = 0;
    res = 1'b1;
    m.valid = 0; m.wr_rd = 0; m.addr = 0; m.wdata = 0;
    b1.valid = 0; b1.wr_rd = 0; b1.addr = 0; b1.wdata = 0;
    b4.valid = 0; b4.wr_rd = 0; b4.addr = 0; b4.wdata = 0;

    // reset for 3 cycles, released mid-clock
    #1;
    chk("rst_ready", m.ready, 0);
    chk("rst_rdata", m.rdata, 0);
    repeat (3) @(posedge clk);
    #2 res = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle_ready", m.ready, 0);
      chk("idle_rdata", m.rdata, 0);
    end

    // single write then read
    xact(1'b1, 4'd5, 8'hA5, lat, rd);
    chk("wr5_lat", lat, 1);
    xact(1'b0, 4'd5, 8'h00, lat, rd);
    chk("rd5_lat", lat, 2);
    chk("rd5_data", rd, 8'hA5);
    chk("rd5_hold", m.rdata, 8'hA5);

    // back-to-back
    for (int i = 0; i < 8; i++) begin
      xact(1'b1, 4'(i), 8'(8'h10 + i), lat, rd);
      chk("b2b_wr_lat", lat, 1);
    end
    chk("wr_keeps_rdata", m.rdata, 8'hA5);
    for (int i = 0; i < 8; i++) begin
      xact(1'b0, 4'(i), 8'h00, lat, rd);
      chk("b2b_rd_lat", lat, 2);
      chk("b2b_rd_data", rd, 8'(8'h10 + i));
    end

    // out of range (DEPTH = 8)
    xact(1'b1, 4'd12, 8'hFF, lat, rd);
    chk("oor_wr_lat", lat, 1);
    xact(1'b0, 4'd12, 8'h00, lat, rd);
    chk("oor_rd_lat", lat, 2);
    chk("oor_rd_data", rd, 8'h00);
    xact(1'b0, 4'd4, 8'h00, lat, rd);
    chk("alias4_data", rd, 8'h14);

    // inputs changing during RD_WAIT are ignored
    xact(1'b1, 4'd2, 8'h5C, lat, rd);
    @(negedge clk);
    m.valid = 1'b1; m.wr_rd = 1'b0; m.addr = 4'd2;
    @(posedge clk);
    #2;
    m.wr_rd = 1'b1; m.addr = 4'd6; m.wdata = 8'hEE;
    @(posedge clk);
    #1;
    chk("chg_ready", m.ready, 1);
    chk("chg_rdata", m.rdata, 8'h5C);
    @(negedge clk);
    m.valid = 1'b0;
    @(posedge clk);
    xact(1'b0, 4'd6, 8'h00, lat, rd);
    chk("chg_no_wr", rd, 8'h16);

    // reset during RD_WAIT
    @(negedge clk);
    m.valid = 1'b1; m.wr_rd = 1'b0; m.addr = 4'd3;
    @(posedge clk);
    #1 chk("mid_wait_ready", m.ready, 0);
    #2 res = 1'b1;
    #1;
    m.valid = 1'b0;
    chk("mid_rst_ready", m.ready, 0);
    chk("mid_rst_rdata", m.rdata, 0);
    repeat (2) begin
      @(posedge clk);
      #1 chk("in_rst_ready", m.ready, 0);
    end
    #4 res = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("post_rst_ready", m.ready, 0);
    end
    xact(1'b0, 4'd3, 8'h00, lat, rd);
    chk("clr3_lat", lat, 2);
    chk("clr3_data", rd, 8'h00);
    xact(1'b0, 4'd7, 8'h00, lat, rd);
    chk("clr7_data", rd, 8'h00);

    // latency sweep: write both, then read both
    @(negedge clk);
    b1.valid = 1; b1.wr_rd = 1; b1.addr = 4'd9; b1.wdata = 8'h3C;
    b4.valid = 1; b4.wr_rd = 1; b4.addr = 4'd9; b4.wdata = 8'h3C;
    @(posedge clk);
    #1;
    chk("l1_wr_ready", b1.ready, 1);
    chk("l4_wr_ready", b4.ready, 1);
    @(negedge clk);
    b1.valid = 0;
    b4.valid = 0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    b1.valid = 1; b1.wr_rd = 0;
    b4.valid = 1; b4.wr_rd = 0;
    lat1 = 0; lat4 = 0; np1 = 0; np4 = 0; rd1 = 0; rd4 = 0;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      #1;
      if (b1.ready === 1'b1) begin
        np1++;
        if (lat1 == 0) begin lat1 = k; rd1 = b1.rdata; end
      end
      if (b4.ready === 1'b1) begin
        np4++;
        if (lat4 == 0) begin lat4 = k; rd4 = b4.rdata; end
      end
      @(negedge clk);
      if (lat1 != 0) b1.valid = 0;
      if (lat4 != 0) b4.valid = 0;
      @(posedge clk);
    end
    chk("l1_rd_lat", lat1, 1);
    chk("l4_rd_lat", lat4, 4);
    chk("l1_rd_data", rd1, 8'h3C);
    chk("l4_rd_data", rd4, 8'h3C);
    chk("l1_pulses", np1, 1);
    chk("l4_pulses", np4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
